// File: rtl/srl_fifo_rd64x11_pkg.sv
// Shared sizing for the SRL-based delay-line and FIFO blocks.
// Word and occupancy types are kept here so sibling blocks agree on widths.
package srl_fifo_rd64x11_pkg;

    localparam int WIDTH = 11;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 1;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [AW-1:0]    addr_t;
    typedef logic [OCC_W-1:0] occ_t;

    localparam occ_t OCC_FULL = occ_t'(DEPTH);

endpackage

// File: rtl/srl_fifo_rd64x11_if.sv
// Write/read handshake bundle of the SRL FIFO.
// slave is the FIFO side; master is the producer/consumer side.
interface srl_fifo_rd64x11_if;
    import srl_fifo_rd64x11_pkg::*;

    word_t wr_d;
    logic  wr_en;
    logic  full;
    word_t rd_q;
    logic  rd_valid;
    logic  rd_ready;
    occ_t  count;
    logic  ovf;

    modport slave (
        input  wr_d,
        input  wr_en,
        input  rd_ready,
        output full,
        output rd_q,
        output rd_valid,
        output count,
        output ovf
    );

    modport master (
        output wr_d,
        output wr_en,
        output rd_ready,
        input  full,
        input  rd_q,
        input  rd_valid,
        input  count,
        input  ovf
    );

endinterface

// File: rtl/srl_fifo_rd64x11_store.sv
// Addressable shift register: newest word at address 0.
// No reset so it maps onto SRL primitives.
module srl_store #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    a,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            mem[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign y = mem[a];

endmodule

// File: rtl/srl_fifo_rd64x11.sv
// Read end of a FWFT FIFO on an SRL store: occupancy tracking,
// oldest-entry addressing and a registered valid/ready output stage.
module srl_fifo_rd64x11
    import srl_fifo_rd64x11_pkg::*;
(
    input logic               clk,
    input logic               rst,
    srl_fifo_rd64x11_if.slave bus
);

    occ_t  scnt_q, scnt_d;
    word_t rd_q_q, rd_q_d;
    logic  rd_valid_q, rd_valid_d;
    logic  ovf_q, ovf_d;

    logic  load;
    logic  wr_acc;
    addr_t rd_addr;
    word_t store_y;

    // Oldest entry sits at scnt-1; address is don't-care when empty.
    assign rd_addr = addr_t'(scnt_q - occ_t'(1));

    assign load = (scnt_q != '0)
               && (!rd_valid_q || bus.rd_ready);

    // A full store still accepts when the tail is read out this edge.
    assign wr_acc = bus.wr_en
                 && ((scnt_q != OCC_FULL) || load);

    srl_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk (clk),
        .ce  (wr_acc),
        .d   (bus.wr_d),
        .a   (rd_addr),
        .y   (store_y)
    );

    always_comb begin
        scnt_d     = scnt_q + occ_t'(wr_acc)
                   - occ_t'(load);
        rd_q_d     = load ? store_y : rd_q_q;
        rd_valid_d = load
                  || (rd_valid_q && !bus.rd_ready);
        ovf_d      = ovf_q || (bus.wr_en && !wr_acc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt_q     <= '0;
            rd_q_q     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            scnt_q     <= scnt_d;
            rd_q_q     <= rd_q_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.full     = (scnt_q == OCC_FULL);
    assign bus.count    = scnt_q + occ_t'(rd_valid_q);
    assign bus.rd_q     = rd_q_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: doc/srl_fifo_rd64x11.md
Name: srl_fifo_rd64x11

Overview:
- First-word-fall-through FIFO built on a 64-stage × 11-bit addressable shift-register store.
- The write side simply shifts data in. This block is the read end: it tracks occupancy, drives the store's output address to the oldest entry, and presents it through a registered valid/ready output stage.
- Sits between sample producers (no back-pressure) and DSP consumers that stall.

Parameters:
- WIDTH, 11, data width.
- DEPTH, 64, shift-register stages (power of 2).
- AW, 6, log2(DEPTH); store address width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_d  in  WIDTH  write data.
- wr_en  in  1  write request; producer does not wait.
- full  out  1  store full; a write is accepted only if a pop frees space that cycle.
- rd_q  out  WIDTH  oldest entry (output register).
- rd_valid  out  1  rd_q holds valid data.
- rd_ready  in  1  consumer accepts rd_q; a pop occurs when rd_valid && rd_ready.
- count  out  AW+1  total occupancy, 0..DEPTH+1 (store plus output register).
- ovf  out  1  sticky: a write was dropped.

Behaviour:
- Reset (async, immediate): scnt=0, rd_valid=0, rd_q=0, full=0, count=0, ovf=0. Store contents are not reset and are never read while scnt=0.
- scnt (0..DEPTH) is the store occupancy. The oldest entry is at store address scnt-1; the newest is at address 0.
- load = (scnt>0) && (!rd_valid || rd_ready). Output register takes store[scnt-1], read combinationally before the edge.
- wr_acc = wr_en && (scnt<DEPTH || load). When accepted, the store shifts in wr_d (store CE = wr_acc).
- scnt_next = scnt + wr_acc - load. rd_valid_next = load || (rd_valid && !rd_ready).
- Full with simultaneous load: address DEPTH-1 is read and shifted out on the same edge. Data is preserved and the write is accepted.
- Full without load: write dropped, store untouched, ovf set until rst.
- Simultaneous write and load at scnt=1: the old entry loads and the new entry moves to address 0. scnt stays 1.
- Latency: write into an empty FIFO → rd_valid high 2 cycles later (no bypass path).
- rd_q holds its value while rd_valid && !rd_ready. rd_ready while !rd_valid is ignored.
- full = (scnt==DEPTH). count = scnt + rd_valid. Both are registered-derived with no combinational path from inputs.
- Throughput: 1 word/clk sustained with rd_ready held high.
- Reset asserted mid-stream empties the FIFO at once; the first post-reset write follows the 2-cycle latency.

Decomposition:
- Shared package: WIDTH/DEPTH/AW defaults and an occupancy-type constant (AW+1 bits). These are reused by sibling delay-line blocks.
- One sub-module: srl_store — a DEPTH×WIDTH addressable shift register (d, a, ce, clk → y). It has no reset and maps to SRL primitives.
- Control (scnt, load, wr_acc, output register, ovf) stays in this module.

Test Plan:
- Reset then single write 0x155, rd_ready=1 → rd_valid rises exactly 2 clk after wr_en, rd_q=0x155, count goes 1→1→0.
- Burst write 0..64 (65 words), rd_ready=0 → full=1 after 65th write, count=65. A 66th write 0x7FF is dropped and ovf=1. Draining yields 0..64 in order.
- Full FIFO, wr_en and rd_ready both high for 10 cycles with data 100..109 → no drops, ovf stays 0, output order continuous, count constant 65.
- Streaming writes 1 word/clk with rd_ready toggling 1,0,1,0 → rd_q stable while stalled, no loss or duplication, sequence matches a reference model.
- scnt=1 and output register valid, write 0x2AA with pop same cycle → next rd_q is the older word, then 0x2AA. count stays 2.
- rst asserted asynchronously mid-burst at count=20 → rd_valid, full, count, ovf go 0 without waiting for a clock edge. The next write of 0x011 appears 2 cycles later.
